// File: rtl/clk_gen.sv
// ----------------------------------------------------------------------------
// clk_gen
// Programmable square-wave / pulse-train generator running on the system
// clock. The period and high time are given in system clock ticks. It runs
// either a burst of N output cycles or continuously (N = 0) until stopped.
//
// Ports
//   in_sys_clk   system clock, all logic on its rising edge
//   in_reset_n   asynchronous active-low reset (synchronous release upstream)
//   in_start     start request, sampled only in IDLE
//   in_stop      abort request, has priority over in_start
//   in_period    output period in ticks, latched on an accepted start
//   in_high      high time in ticks, latched on an accepted start
//   in_count     output cycles per burst, 0 = continuous
//   out_clk      generated waveform (registered)
//   out_busy     high while in RUN
//   out_cycle    one-tick pulse coincident with each out_clk rising edge
//   out_done     one-tick pulse when a burst completes normally
//   out_err      sticky flag: last start was rejected for a bad config
//
// State table
//   state | meaning
//   IDLE  | waiting for a start request; all waveform outputs low
//   RUN   | generating the waveform from the latched period/high/count
// ----------------------------------------------------------------------------
module clk_gen #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 in_sys_clk,
    input  logic                 in_reset_n,
    input  logic                 in_start,
    input  logic                 in_stop,
    input  logic [WIDTH-1:0]     in_period,
    input  logic [WIDTH-1:0]     in_high,
    input  logic [CNT_WIDTH-1:0] in_count,
    output logic                 out_clk,
    output logic                 out_busy,
    output logic                 out_cycle,
    output logic                 out_done,
    output logic                 out_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]           state;
    logic [WIDTH-1:0]     p_reg;
    logic [WIDTH-1:0]     h_reg;
    logic [CNT_WIDTH-1:0] n_reg;
    logic [WIDTH-1:0]     phase;
    logic [CNT_WIDTH-1:0] cycles;

    logic                 cfg_ok;
    logic                 wrap;
    logic [WIDTH-1:0]     phase_n;
    logic [CNT_WIDTH-1:0] cycles_inc;
    logic                 burst_end;

    always_comb begin
        cfg_ok     = (in_period >= WIDTH'(2)) && (in_high != '0) && (in_high < in_period);
        wrap       = (phase == (p_reg - WIDTH'(1)));
        phase_n    = wrap ? '0 : (phase + WIDTH'(1));
        cycles_inc = cycles + CNT_WIDTH'(1);
        // The last tick of a finite burst: final phase of the N-th cycle.
        burst_end  = (n_reg != '0) && wrap && (cycles_inc == n_reg);
    end

    always_ff @(posedge in_sys_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state     <= ST_IDLE;
            p_reg     <= '0;
            h_reg     <= '0;
            n_reg     <= '0;
            phase     <= '0;
            cycles    <= '0;
            out_clk   <= 1'b0;
            out_busy  <= 1'b0;
            out_cycle <= 1'b0;
            out_done  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            out_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    out_clk   <= 1'b0;
                    out_busy  <= 1'b0;
                    out_cycle <= 1'b0;
                    if (in_start && !in_stop) begin
                        if (cfg_ok) begin
                            p_reg     <= in_period;
                            h_reg     <= in_high;
                            n_reg     <= in_count;
                            phase     <= '0;
                            cycles    <= '0;
                            out_err   <= 1'b0;
                            state     <= ST_RUN;
                            out_clk   <= 1'b1;
                            out_cycle <= 1'b1;
                            out_busy  <= 1'b1;
                        end else begin
                            out_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (in_stop) begin
                        // Abort wins even on the final tick, so no done pulse.
                        state     <= ST_IDLE;
                        out_clk   <= 1'b0;
                        out_busy  <= 1'b0;
                        out_cycle <= 1'b0;
                    end else if (burst_end) begin
                        state     <= ST_IDLE;
                        out_clk   <= 1'b0;
                        out_busy  <= 1'b0;
                        out_cycle <= 1'b0;
                        out_done  <= 1'b1;
                    end else begin
                        phase     <= phase_n;
                        out_clk   <= (phase_n < h_reg);
                        out_cycle <= (phase_n == '0);
                        if (wrap) begin
                            cycles <= cycles_inc;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_gen.sv
module tb_clk_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [31:0] period;
    logic [31:0] high;
    logic [15:0] count;
    logic        o_clk, o_busy, o_cycle, o_done, o_err;

    int checks = 0;
    int errors = 0;

    // Expected {clk, busy, cycle, done, err} after each rising edge.
    logic [4:0] sb[$];

    clk_gen #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .in_sys_clk (clk),
        .in_reset_n (rst_n),
        .in_start   (start),
        .in_stop    (stop),
        .in_period  (period),
        .in_high    (high),
        .in_count   (count),
        .out_clk    (o_clk),
        .out_busy   (o_busy),
        .out_cycle  (o_cycle),
        .out_done   (o_done),
        .out_err    (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got clk/busy/cycle/done/err=%b want %b", name, $time, got, want);
        end
    endtask

    // Reference model: tracks the tick offset k since the accepted start and
    // derives the waveform from k mod P; a burst lasts exactly N*P ticks.
    bit      m_run  = 1'b0;
    bit      m_err  = 1'b0;
    bit      m_done;
    longint  m_k, m_p, m_h, m_n;
    logic [4:0] m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0;
            m_err = 1'b0;
            sb.delete();
        end else begin
            m_done = 1'b0;
            if (!m_run) begin
                if (start && !stop) begin
                    if (period >= 2 && high >= 1 && high < period) begin
                        m_p   = longint'(period);
                        m_h   = longint'(high);
                        m_n   = longint'(count);
                        m_k   = 0;
                        m_run = 1'b1;
                        m_err = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (stop) begin
                m_run = 1'b0;
            end else begin
                m_k++;
                if (m_n != 0 && m_k == m_n * m_p) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (m_run)
                m_exp = {((m_k % m_p) < m_h), 1'b1, ((m_k % m_p) == 0), 1'b0, m_err};
            else
                m_exp = {3'b000, m_done, m_err};
            sb.push_back(m_exp);
        end
    end

    // Monitor: outputs are sampled on the falling edge, away from the DUT edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_state", {o_clk, o_busy, o_cycle, o_done, o_err}, 5'b0);
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t: got no expected entry, want one per tick", $time);
        end else begin
            check("waveform", {o_clk, o_busy, o_cycle, o_done, o_err}, sb.pop_front());
        end
    end

    task automatic set_in(input bit s, input bit t, input logic [31:0] p,
                          input logic [31:0] h, input logic [15:0] n);
        @(negedge clk);
        start  = s;
        stop   = t;
        period = p;
        high   = h;
        count  = n;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        period = '0;
        high   = '0;
        count  = '0;
        #23 rst_n = 1'b1;
        idle(2);

        // Burst P=4 H=2 N=3.
        set_in(1, 0, 4, 2, 3);
        idle(16);

        // Continuous P=2 H=1, stopped after 10 ticks.
        set_in(1, 0, 2, 1, 0);
        idle(9);
        set_in(0, 1, 2, 1, 0);
        idle(4);

        // Illegal H == P, then a legal single-cycle burst clears the error.
        set_in(1, 0, 4, 4, 1);
        idle(2);
        set_in(1, 0, 5, 1, 1);
        idle(8);

        // Start during a P=8 burst is ignored.
        set_in(1, 0, 8, 3, 2);
        idle(5);
        set_in(1, 0, 3, 1, 1);
        idle(20);

        // Reset mid-burst at phase 1: outputs clear without waiting for a clock.
        set_in(1, 0, 6, 2, 3);
        idle(1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {o_clk, o_busy, o_cycle, o_done, o_err}, 5'b0);
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;
        idle(5);

        // Start+stop together keeps IDLE and leaves a set error flag alone.
        set_in(1, 0, 3, 0, 1);
        idle(1);
        set_in(1, 1, 4, 2, 1);
        idle(3);
        // Stop on the final tick of an N=2 burst: no done.
        set_in(1, 0, 3, 1, 2);
        idle(5);
        set_in(0, 1, 3, 1, 2);
        idle(4);

        // Wide unsigned compare: values above 2^31.
        set_in(1, 0, 32'h8000_0002, 32'h8000_0001, 0);
        idle(6);
        set_in(0, 1, 0, 0, 0);
        idle(2);

        // Random traffic: starts, stops and configs, legal and illegal.
        for (int i = 0; i < 700; i++) begin
            set_in(($urandom % 6) == 0, ($urandom % 20) == 0,
                   32'($urandom_range(0, 9)), 32'($urandom_range(0, 9)),
                   16'($urandom_range(0, 3)));
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
